imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised, loadable instruction memory for the LEGv8 fetch stage. A load port fills the memory word by word after reset or on request. Instruction fetches are served with a registered one-cycle read. Unloaded locations return the architectural NOP, and fetch is stalled while a load is in progress.

## Interface
Parameters:
- `N`, 32: instruction word width.
- `ADDR_W`, 6: word-address width.
- `DEPTH`, 64: number of words; must satisfy `DEPTH <= 2**ADDR_W`.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `addr` in ADDR_W: fetch word address (word index, not byte address).
- `req` in 1: fetch request.
- `q` out N: fetched instruction.
- `valid` out 1: `q` holds the result of the previous-cycle request.
- `stall` out 1: fetch must hold its PC.
- `ld_start` in 1: restarts loading from word 0.
- `ld_valid` in 1: `ld_data` is offered.
- `ld_data` in N: word to store.
- `ld_last` in 1: qualifies the final word of an image.
- `ld_ready` out 1: the load port accepts words.
- `ld_done` out 1: one-cycle pulse when loading completes.
- `perr` out 1: parity error on the current `q` (only when `IMEM_PARITY_EN` is defined; tied to 0 otherwise).

## Operation
- States: `LOAD`, `RUN`. Reset enters `LOAD`.
- `LOAD`:
  - `ld_ready=1`, `stall=1`.
  - A word is accepted when `ld_valid & ld_ready`. It is written at `wr_ptr`, then `wr_ptr++` and `cnt++`.
  - Exit to `RUN` on the accepted word that has `ld_last=1`, or on the accepted word at `wr_ptr==DEPTH-1`, whichever comes first.
  - `ld_done` pulses in the cycle after that acceptance.
  - `req` is ignored.
- `RUN`:
  - `ld_ready=0`, `stall=0`.
  - `req` reads `mem[addr]`.
  - If `addr >= cnt`, `q` is `NOP` (32'hd503201f) instead of memory contents.
- `ld_start` from either state:
  - Clears `wr_ptr` and `cnt` and enters `LOAD`.
  - Any read in flight is cancelled: `valid=0` next cycle.
- `ld_start` takes priority over `req` and over a simultaneous load acceptance; the offered word is dropped.
- `cnt` is `ADDR_W+1` bits wide; it saturates at `DEPTH` and never wraps.
- Memory contents are not cleared by reset or `ld_start`. Only `cnt` defines which words are live.
- If `reset` is asserted mid-load, the partial image is discarded (`cnt=0`).

## Timing
- Reset values: `q=0`, `valid=0`, `stall=1`, `ld_ready=1`, `ld_done=0`, `perr=0`, `cnt=0`, `wr_ptr=0`.
- Read latency:
  - `req` with `addr` sampled at edge t.
  - `q` and `valid` are registered and visible after edge t.
  - `valid` is high for exactly one cycle per request; back-to-back requests give one result per cycle.
- `q` holds its last value when `valid=0`.
- Load throughput: one word per cycle.
- `stall` falls in the same cycle `ld_done` pulses. The first `req` is accepted at that cycle's closing edge.
- `ld_ready` and `stall` are decoded from the state register, with no combinational path from inputs.

## Configuration
- `IMEM_PARITY_EN` defined:
  - Each stored word carries an even-parity bit computed on write.
  - On a read of a live address, recomputed parity is compared with the stored bit. A mismatch sets `perr=1` alongside `valid`.
  - `q` still returns the stored data.
  - The NOP substitution path always has `perr=0`.
- `IMEM_PARITY_EN` undefined: no parity storage; `perr` is constant 0.

## Structure
- `imem_pkg` holds:
  - `NOP` constant, 32'hd503201f.
  - `state_t` enum (`LOAD`, `RUN`).
  - Parity function.
- Sub-module `imem_ram`: single-port synchronous RAM with parameters `W` and `DEPTH`. It has write enable and registered read data; in `LOAD` it writes, in `RUN` it reads.
- The top level holds the FSM, `wr_ptr`, `cnt`, the NOP mux and the `valid` register.

## Test plan
- Reset, then load 20 words with `ld_last` on the 20th (word 0 = 32'h8b1f03e0, word 5 = 32'h91002001) -> `ld_done` one pulse, `cnt=20`, `stall` low. `req addr=5` -> next cycle `q=32'h91002001`, `valid=1`.
- In `RUN`, `req addr=20` and `addr=63` -> `q=32'hd503201f`, `valid=1`.
- Stream 64 words with no `ld_last` -> automatic `RUN` after word 63, `cnt=64`. `req addr=63` returns word 63.
- `ld_start` in the same cycle as `req addr=0` -> `valid=0` next cycle, `stall=1`, `ld_ready=1`. Reload 3 words -> `addr=3` returns NOP.
- Assert `reset` after 10 of 20 words loaded -> all outputs at reset values, `cnt=0`. `ld_valid` with `ld_last` accepted at `wr_ptr=0`.
- With `IMEM_PARITY_EN`, force-flip bit 0 of stored word 2 -> `req addr=2` gives `valid=1`, `perr=1`. `req addr=1` gives `perr=0`.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the loadable instruction memory.
//   NOP     - architectural LEGv8 NOP returned for unloaded locations
//   state_t - load/run state of the memory controller
//   parity  - even-parity helper used when IMEM_PARITY_EN is defined
package imem_pkg;

    localparam logic [31:0] NOP = 32'hd503201f;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Returns the bit that makes the total number of ones even.
    function automatic logic parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-port synchronous RAM with registered read data.
// Parameters:
//   W      - word width
//   DEPTH  - number of words
//   ADDR_W - address width
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset (clears the read register only)
//   we    - write enable, writes wdata at addr
//   re    - read enable, loads mem[addr] into rdata
//   addr  - shared word address
//   wdata - write data
//   rdata - registered read data, holds when re is low
module imem_ram #(
    parameter int unsigned W      = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    // Array contents are intentionally not reset; the controller's count
    // decides which words are live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: loadable instruction memory for the LEGv8 fetch stage.
// A load port fills the memory word by word from word 0; fetches are served
// with a registered one-cycle read once loading has finished. Addresses at or
// beyond the loaded word count return the architectural NOP.
// Build option: define IMEM_PARITY_EN to store an even-parity bit per word
// and report mismatches on perr; otherwise perr is tied to 0.
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   addr, req           - fetch word address and request
//   q, valid            - fetched word and its one-cycle valid flag
//   stall               - fetch must hold its PC (high while loading)
//   ld_start            - restart loading from word 0 (cancels reads)
//   ld_valid, ld_data   - offered load word
//   ld_last             - marks the final word of an image
//   ld_ready            - load port accepts words
//   ld_done             - one-cycle pulse after the final word is accepted
//   perr                - parity error on the current q
module imem_loadable
    import imem_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              req,
    output logic [N-1:0]      q,
    output logic              valid,
    output logic              stall,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [N-1:0]      ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              perr
);

`ifdef IMEM_PARITY_EN
    localparam int unsigned W = N + 1;
`else
    localparam int unsigned W = N;
`endif

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_MAX  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              valid_q;
    logic              nop_q;
    logic              ld_done_q;

    logic              accept;
    logic              last_word;
    logic              rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [W-1:0]      ram_wdata;
    logic [W-1:0]      ram_rdata;

    // Handshake outputs come straight from the state register.
    assign ld_ready = (state_q == LOAD);
    assign stall    = (state_q == LOAD);

    // ld_start wins over both a load acceptance and a fetch.
    assign accept    = ld_ready & ld_valid & ~ld_start;
    assign last_word = ld_last | (wr_ptr_q == LAST_PTR);
    assign rd_en     = (state_q == RUN) & req & ~ld_start;
    assign ram_addr  = (state_q == LOAD) ? wr_ptr_q : addr;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (ld_start) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (last_word) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LOAD;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            nop_q     <= 1'b0;
            ld_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            valid_q   <= rd_en;
            ld_done_q <= accept & last_word;
            // Liveness is captured with the read so q holds between requests.
            if (rd_en) begin
                nop_q <= ({1'b0, addr} >= cnt_q);
            end
        end
    end

`ifdef IMEM_PARITY_EN
    assign ram_wdata = {parity(64'(ld_data)), ld_data};
    assign perr      = valid_q & ~nop_q & (parity(64'(ram_rdata[N-1:0])) != ram_rdata[N]);
`else
    assign ram_wdata = ld_data;
    assign perr      = 1'b0;
`endif

    imem_ram #(
        .W      (W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .re    (rd_en),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign q       = nop_q ? N'(NOP) : ram_rdata[N-1:0];
    assign valid   = valid_q;
    assign ld_done = ld_done_q;

endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: directed bench for imem_loadable with a behavioural
// image model (array + live word count) compared against the DUT every cycle.
module tb_imem_loadable;

    localparam logic [31:0] NOP_W = 32'hd503201f;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  addr;
    logic        req;
    logic [31:0] q;
    logic        valid;
    logic        stall;
    logic        ld_start;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_done;
    logic        perr;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    // Model state: image contents, number of live words, loading flag.
    logic [31:0] m_mem [DEPTH];
    logic        m_flip [DEPTH];
    int          m_cnt;
    logic        m_loading;
    logic [31:0] e_q;
    logic        e_valid;
    logic        e_done;
    logic        e_perr;

    imem_loadable #(
        .N      (32),
        .ADDR_W (6),
        .DEPTH  (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .req      (req),
        .q        (q),
        .valid    (valid),
        .stall    (stall),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .perr     (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i, input int seed);
        if (seed == 0 && i == 0) return 32'h8b1f03e0;
        if (seed == 0 && i == 5) return 32'h91002001;
        return (32'h10000000 + 32'(i) * 32'h00010001) ^ 32'(seed);
    endfunction

    // Behavioural model: a load appends to the image until the marked last
    // word or a full image; a fetch returns the image word or NOP if unloaded.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_loading <= 1'b1;
            m_cnt     <= 0;
            e_q       <= '0;
            e_valid   <= 1'b0;
            e_done    <= 1'b0;
            e_perr    <= 1'b0;
        end else begin
            e_valid <= 1'b0;
            e_done  <= 1'b0;
            e_perr  <= 1'b0;
            if (ld_start) begin
                m_loading <= 1'b1;
                m_cnt     <= 0;
            end else if (m_loading) begin
                if (ld_valid) begin
                    m_mem[m_cnt] <= ld_data;
                    m_cnt        <= m_cnt + 1;
                    if (ld_last || m_cnt == DEPTH - 1) begin
                        m_loading <= 1'b0;
                        e_done    <= 1'b1;
                    end
                end
            end else if (req) begin
                e_valid <= 1'b1;
                if (int'(addr) < m_cnt) begin
                    e_q    <= m_mem[addr] ^ {31'b0, m_flip[addr]};
                    e_perr <= m_flip[addr];
                end else begin
                    e_q <= NOP_W;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q", q, e_q);
            chk("valid", {31'b0, valid}, {31'b0, e_valid});
            chk("stall", {31'b0, stall}, {31'b0, m_loading});
            chk("ld_ready", {31'b0, ld_ready}, {31'b0, m_loading});
            chk("ld_done", {31'b0, ld_done}, {31'b0, e_done});
            chk("perr", {31'b0, perr}, {31'b0, e_perr});
        end
    end

    task automatic load(input int n, input bit mark_last, input int seed);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = word(i, seed);
            ld_last  = mark_last && (i == n - 1);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic rd(input int a);
        req  = 1'b1;
        addr = 6'(a);
        @(negedge clk);
        req  = 1'b0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        addr     = '0;
        req      = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_flip[i] = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;

        // Reset values
        chk("rst q", q, 32'h0);
        chk("rst valid", {31'b0, valid}, 32'h0);
        chk("rst stall", {31'b0, stall}, 32'h1);
        chk("rst ld_ready", {31'b0, ld_ready}, 32'h1);
        chk("rst cnt", 32'(dut.cnt_q), 32'h0);
        reset = 1'b0;

        // 20-word image with ld_last on the 20th
        load(20, 1'b1, 0);
        chk("img20 ld_done", {31'b0, ld_done}, 32'h1);
        chk("img20 stall", {31'b0, stall}, 32'h0);
        chk("img20 cnt", 32'(dut.cnt_q), 32'd20);
        @(negedge clk);
        chk("img20 ld_done once", {31'b0, ld_done}, 32'h0);
        rd(5);
        chk("rd5 q", q, 32'h91002001);
        chk("rd5 valid", {31'b0, valid}, 32'h1);
        rd(0);
        chk("rd0 q", q, 32'h8b1f03e0);
        // Back-to-back reads past the image
        req = 1'b1; addr = 6'd20;
        @(negedge clk);
        chk("rd20 q", q, NOP_W);
        addr = 6'd63;
        @(negedge clk);
        chk("rd63 q", q, NOP_W);
        chk("rd63 valid", {31'b0, valid}, 32'h1);
        req = 1'b0;
        @(negedge clk);
        chk("idle valid", {31'b0, valid}, 32'h0);
        chk("idle q hold", q, NOP_W);

        // Full 64-word image without ld_last
        pulse_start();
        chk("restart stall", {31'b0, stall}, 32'h1);
        load(64, 1'b0, 7);
        chk("full ld_done", {31'b0, ld_done}, 32'h1);
        chk("full cnt", 32'(dut.cnt_q), 32'd64);
        rd(63);
        chk("full rd63 q", q, word(63, 7));

        // ld_start together with a fetch cancels the read
        ld_start = 1'b1; req = 1'b1; addr = 6'd0;
        @(negedge clk);
        ld_start = 1'b0; req = 1'b0;
        chk("cancel valid", {31'b0, valid}, 32'h0);
        chk("cancel stall", {31'b0, stall}, 32'h1);
        chk("cancel ld_ready", {31'b0, ld_ready}, 32'h1);
        load(3, 1'b1, 3);
        rd(3);
        chk("img3 rd3 q", q, NOP_W);
        rd(2);
        chk("img3 rd2 q", q, word(2, 3));
        rd(5);
        chk("img3 rd5 q", q, NOP_W);

        // Reset in the middle of a load
        pulse_start();
        load(10, 1'b0, 9);
        ld_valid = 1'b1; ld_data = word(10, 9);
        #2 reset = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0;
        chk("midrst q", q, 32'h0);
        chk("midrst valid", {31'b0, valid}, 32'h0);
        chk("midrst stall", {31'b0, stall}, 32'h1);
        chk("midrst ld_ready", {31'b0, ld_ready}, 32'h1);
        chk("midrst ld_done", {31'b0, ld_done}, 32'h0);
        chk("midrst cnt", 32'(dut.cnt_q), 32'h0);
        reset = 1'b0;
        ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'hcafef00d;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("one ld_done", {31'b0, ld_done}, 32'h1);
        chk("one cnt", 32'(dut.cnt_q), 32'h1);
        rd(0);
        chk("one rd0 q", q, 32'hcafef00d);
        rd(1);
        chk("one rd1 q", q, NOP_W);

        // Parity
        pulse_start();
        load(4, 1'b1, 5);
`ifdef IMEM_PARITY_EN
        dut.u_ram.mem[2][0] = ~dut.u_ram.mem[2][0];
        m_flip[2] = 1'b1;
        rd(2);
        chk("par rd2 valid", {31'b0, valid}, 32'h1);
        chk("par rd2 perr", {31'b0, perr}, 32'h1);
        chk("par rd2 q", q, word(2, 5) ^ 32'h1);
        rd(1);
        chk("par rd1 perr", {31'b0, perr}, 32'h0);
        rd(7);
        chk("par nop perr", {31'b0, perr}, 32'h0);
`else
        rd(2);
        chk("nopar rd2 perr", {31'b0, perr}, 32'h0);
        chk("nopar rd2 q", q, word(2, 5));
`endif
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
